// File: rtl/moore_fsm_arbiter_pkg.sv
// Shared definitions for the Moore FSM arbiter.
//   ctrl_state_t : controller states (IDLE, CLR, SHIFT, DONE)
//   S0..S3       : state codes reported by the shared 2-bit Moore FSM on y_in
//   DEF_*        : default requester count and pattern length
package moore_fsm_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_PATTERN_W = 8;

endpackage

// File: rtl/moore_fsm_arbiter_rr.sv
// Round-robin selector: picks the first asserted req at or after pointer,
// wrapping modulo N_REQ. Purely combinational.
//   req        : request levels
//   pointer    : index with highest priority this round
//   winner     : one-hot winner (all zero when no req)
//   winner_idx : binary index of winner
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    pointer,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    winner_idx
);

    logic found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (int'(pointer) + k) % N_REQ;
            if (!found && req[j]) begin
                found      = 1'b1;
                winner[j]  = 1'b1;
                winner_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/moore_fsm_arbiter.sv
// Shares one external 2-bit Moore FSM among N_REQ requesters. Each granted
// job resets the FSM for one cycle, feeds it the winner's pattern LSB first,
// counts post-bit states equal to S3 and reports the final state.
//   clock, reset : clock, synchronous active-high reset
//   req, pattern : per-requester request level and bit pattern
//   grant, busy  : one-hot owner of the FSM, job in progress
//   x_out        : serial bit into the FSM; fsm_reset_n: FSM reset (low)
//   y_in         : FSM state; result / s3_count: last job's outcome
//   done         : one-cycle completion pulse for the winner
module moore_fsm_arbiter
    import moore_fsm_arbiter_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int PATTERN_W = DEF_PATTERN_W
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [N_REQ-1:0]                     req,
    input  logic [N_REQ-1:0][PATTERN_W-1:0]      pattern,
    output logic [N_REQ-1:0]                     grant,
    output logic                                 busy,
    output logic                                 x_out,
    output logic                                 fsm_reset_n,
    input  logic [1:0]                           y_in,
    output logic [1:0]                           result,
    output logic [$clog2(PATTERN_W+1)-1:0]       s3_count,
    output logic [N_REQ-1:0]                     done
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(PATTERN_W + 1);

    ctrl_state_t          state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        cur_idx;
    logic [PATTERN_W-1:0] shreg;
    logic [CW-1:0]        bit_cnt;
    logic                 fsm_rst_q;
    logic [N_REQ-1:0]     win_oh;
    logic [IW-1:0]        win_idx;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req        (req),
        .pointer    (ptr),
        .winner     (win_oh),
        .winner_idx (win_idx)
    );

    // Gated with reset so the shared FSM is held in reset for the whole
    // time reset is high, not only from the first edge onward.
    assign fsm_reset_n = fsm_rst_q & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cur_idx   <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            x_out     <= 1'b0;
            result    <= '0;
            s3_count  <= '0;
            done      <= '0;
            fsm_rst_q <= 1'b1;
        end else begin
            done      <= '0;
            x_out     <= 1'b0;
            fsm_rst_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= CLR;
                        grant     <= win_oh;
                        busy      <= 1'b1;
                        cur_idx   <= win_idx;
                        shreg     <= pattern[win_idx];
                        s3_count  <= '0;
                        fsm_rst_q <= 1'b0;
                    end
                end
                CLR: begin
                    state   <= SHIFT;
                    x_out   <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    // y_in in SHIFT cycle 0 is the cleared S0, not a post-bit state.
                    if (bit_cnt != '0 && y_in == S3)
                        s3_count <= s3_count + CW'(1);
                    if (bit_cnt == CW'(PATTERN_W - 1)) begin
                        state <= DONE;
                    end else begin
                        x_out   <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (y_in == S3)
                        s3_count <= s3_count + CW'(1);
                    result <= y_in;
                    done   <= grant;
                    grant  <= '0;
                    busy   <= 1'b0;
                    ptr    <= (cur_idx == IW'(N_REQ - 1)) ? '0 : cur_idx + IW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
